// File: rtl/lsu_seq_pkg.sv
// Shared encodings, state codes and command decode for the load/store sequencer.
package lsu_seq_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  localparam logic [2:0] RD_NONE = 3'd0;
  localparam logic [2:0] RD_LB   = 3'd1;
  localparam logic [2:0] RD_LBU  = 3'd2;
  localparam logic [2:0] RD_LH   = 3'd3;
  localparam logic [2:0] RD_LHU  = 3'd4;
  localparam logic [2:0] RD_LW   = 3'd5;
  localparam logic [2:0] RD_LD   = 3'd6;

  localparam logic [2:0] WR_NONE = 3'd0;
  localparam logic [2:0] WR_SB   = 3'd1;
  localparam logic [2:0] WR_SH   = 3'd2;
  localparam logic [2:0] WR_SW   = 3'd3;
  localparam logic [2:0] WR_SD   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef struct packed {
    logic  legal;
    logic  store;
    size_e size;
  } cmd_t;

  // Misalignment is folded into legality so the FSM has a single error path.
  function automatic cmd_t decode_cmd(input logic [2:0] rd, input logic [2:0] wr,
                                      input logic [2:0] a);
    cmd_t c;
    c.legal = 1'b1;
    c.store = (wr != WR_NONE);
    c.size  = SZ_B;
    if (rd != RD_NONE && wr != WR_NONE) c.legal = 1'b0;
    if (c.store) begin
      case (wr)
        WR_SB:   c.size = SZ_B;
        WR_SH:   c.size = SZ_H;
        WR_SW:   c.size = SZ_W;
        WR_SD:   c.size = SZ_D;
        default: c.legal = 1'b0;
      endcase
    end else begin
      case (rd)
        RD_LB, RD_LBU: c.size = SZ_B;
        RD_LH, RD_LHU: c.size = SZ_H;
        RD_LW:         c.size = SZ_W;
        RD_LD:         c.size = SZ_D;
        RD_NONE:       c.size = SZ_B;
        default:       c.legal = 1'b0;
      endcase
    end
    case (c.size)
      SZ_H:    if (a[0])        c.legal = 1'b0;
      SZ_W:    if (a[1:0] != 0) c.legal = 1'b0;
      SZ_D:    if (a != 0)      c.legal = 1'b0;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lsu_ld_extend.sv
// Selects the byte/half lane of a read word and sign- or zero-extends it to XLEN.
module lsu_ld_extend
  import lsu_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        lane,
  input  logic [2:0]        rd,
  output logic [XLEN-1:0]   data
);

  logic [WORD_W-1:0] sh;

  always_comb begin
    sh   = word >> {lane, 3'b000};
    data = '0;
    case (rd)
      RD_LB:   data = {{(XLEN-8){sh[7]}}, sh[7:0]};
      RD_LBU:  data = {{(XLEN-8){1'b0}}, sh[7:0]};
      RD_LH:   data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      RD_LHU:  data = {{(XLEN-16){1'b0}}, sh[15:0]};
      RD_LW:   data = {{(XLEN-32){sh[31]}}, sh[31:0]};
      RD_LD:   data = {{(XLEN-32){1'b0}}, word};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer: splits RV64 accesses into 32-bit bus beats with ack timeout.
module lsu_seq
  import lsu_seq_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int MEM_AW  = 32,
  parameter int ACK_TMO = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        dm_rd_ctrl,
  input  logic [2:0]        dm_wr_ctrl,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              busy
);

  localparam int TW = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [2:0]        rd_q, rd_d;
  logic [1:0]        lane_q, lane_d;
  logic              dbl_q, dbl_d;
  logic              store_q, store_d;
  logic [WORD_W-1:0] wdata_hi_q, wdata_hi_d;
  logic [WORD_W-1:0] lo_q, lo_d;

  cmd_t            cmd;
  logic            tmo_hit;
  logic [XLEN-1:0] ext_data;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^addr[XLEN-1:MEM_AW];

  lsu_ld_extend #(.XLEN(XLEN)) u_ld_extend (
    .word (mem_rdata),
    .lane (lane_q),
    .rd   (rd_q),
    .data (ext_data)
  );

  always_comb begin
    cmd     = decode_cmd(dm_rd_ctrl, dm_wr_ctrl, addr[2:0]);
    tmo_hit = (ACK_TMO != 0) && (tmo_q == TW'(ACK_TMO - 1));

    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    tmo_d        = tmo_q;
    rd_d         = rd_q;
    lane_d       = lane_q;
    dbl_d        = dbl_q;
    store_d      = store_q;
    wdata_hi_d   = wdata_hi_q;
    lo_d         = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && (dm_rd_ctrl != RD_NONE || dm_wr_ctrl != WR_NONE)) begin
          if (cmd.legal) begin
            state_d     = ST_B0;
            mem_req_d   = 1'b1;
            mem_we_d    = cmd.store;
            mem_addr_d  = {addr[MEM_AW-1:2], 2'b00};
            case (cmd.size)
              SZ_B:    mem_be_d = 4'b0001 << addr[1:0];
              SZ_H:    mem_be_d = 4'b0011 << addr[1:0];
              default: mem_be_d = 4'b1111;
            endcase
            mem_wdata_d = cmd.store ? (wdata[WORD_W-1:0] << {addr[1:0], 3'b000}) : '0;
            tmo_d       = '0;
            rd_d        = dm_rd_ctrl;
            lane_d      = addr[1:0];
            dbl_d       = (cmd.size == SZ_D);
            store_d     = cmd.store;
            wdata_hi_d  = wdata[2*WORD_W-1:WORD_W];
          end else begin
            state_d      = ST_ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      ST_B0, ST_B1: begin
        if (mem_ack) begin
          if (state_q == ST_B0 && dbl_q) begin
            state_d     = ST_B1;
            mem_addr_d  = mem_addr_q + MEM_AW'(4);
            mem_wdata_d = store_q ? wdata_hi_q : '0;
            lo_d        = mem_rdata;
            tmo_d       = '0;
          end else begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            if (!store_q) resp_rdata_d = dbl_q ? {mem_rdata, lo_q} : ext_data;
          end
        end else if (tmo_hit) begin
          state_d      = ST_ERR;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
        // Bus is released whenever the beat sequence ends, by completion or timeout.
        if (state_d == ST_DONE || state_d == ST_ERR) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
        end
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      tmo_q        <= '0;
      rd_q         <= RD_NONE;
      lane_q       <= '0;
      dbl_q        <= 1'b0;
      store_q      <= 1'b0;
      wdata_hi_q   <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      tmo_q        <= tmo_d;
      rd_q         <= rd_d;
      lane_q       <= lane_d;
      dbl_q        <= dbl_d;
      store_q      <= store_d;
      wdata_hi_q   <= wdata_hi_d;
      lo_q         <= lo_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq with a short ack timeout so the timeout path is reachable.
module tb_lsu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  dm_rd_ctrl, dm_wr_ctrl;
  logic [63:0] addr, wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        resp_valid, resp_err, busy;
  logic [63:0] resp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_seq #(.XLEN(64), .MEM_AW(32), .ACK_TMO(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] rd, input logic [2:0] wr,
                       input logic [63:0] a, input logic [63:0] wd);
    req_valid  = 1'b1;
    dm_rd_ctrl = rd;
    dm_wr_ctrl = wr;
    addr       = a;
    wdata      = wd;
    tick();
    req_valid  = 1'b0;
    dm_rd_ctrl = 3'd0;
    dm_wr_ctrl = 3'd0;
  endtask

  typedef struct packed {
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [63:0] a;
    logic [63:0] wd;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [63:0] exp_rd;
  } vec_t;

  typedef struct packed {
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [63:0] a;
  } bad_t;

  vec_t vecs[8];
  bad_t bads[5];

  initial begin
    vecs[0] = '{3'd1, 3'd0, 64'h1003, 64'h0, 32'h8012_3456, 32'h1000, 4'b1000, 32'h0, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1] = '{3'd4, 3'd0, 64'h2002, 64'h0, 32'hBEEF_0000, 32'h2000, 4'b1100, 32'h0, 64'h0000_0000_0000_BEEF};
    vecs[2] = '{3'd3, 3'd0, 64'h9000, 64'h0, 32'h1234_8001, 32'h9000, 4'b0011, 32'h0, 64'hFFFF_FFFF_FFFF_8001};
    vecs[3] = '{3'd2, 3'd0, 64'h9001, 64'h0, 32'h0000_FF00, 32'h9000, 4'b0010, 32'h0, 64'h0000_0000_0000_00FF};
    vecs[4] = '{3'd5, 3'd0, 64'hA004, 64'h0, 32'h8000_0001, 32'hA004, 4'b1111, 32'h0, 64'hFFFF_FFFF_8000_0001};
    vecs[5] = '{3'd0, 3'd1, 64'h8001, 64'hAB, 32'hFFFF_FFFF, 32'h8000, 4'b0010, 32'h0000_AB00, 64'h0};
    vecs[6] = '{3'd0, 3'd2, 64'h8002, 64'hCAFE, 32'hFFFF_FFFF, 32'h8000, 4'b1100, 32'hCAFE_0000, 64'h0};
    vecs[7] = '{3'd0, 3'd3, 64'hA000, 64'hFFFF_0000_DEAD_BEEF, 32'h0, 32'hA000, 4'b1111, 32'hDEAD_BEEF, 64'h0};

    bads[0] = '{3'd5, 3'd0, 64'h4002};
    bads[1] = '{3'd1, 3'd1, 64'h4000};
    bads[2] = '{3'd7, 3'd0, 64'h4000};
    bads[3] = '{3'd0, 3'd5, 64'h4000};
    bads[4] = '{3'd0, 3'd4, 64'h3004};

    rst_n = 1'b0; req_valid = 1'b0; dm_rd_ctrl = 3'd0; dm_wr_ctrl = 3'd0;
    addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst_ready", req_ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rdata", resp_rdata, 0);
    rst_n = 1'b1;
    tick();

    issue(3'd0, 3'd0, 64'h1000, 64'h0);
    check("noop_ready", req_ready, 1);
    check("noop_req", mem_req, 0);

    // Single-beat ops with immediate ack: resp_valid at N+2.
    foreach (vecs[i]) begin
      issue(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd);
      check($sformatf("v%0d_req", i), mem_req, 1);
      check($sformatf("v%0d_we", i), mem_we, (vecs[i].wr != 0));
      check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_be", i), mem_be, vecs[i].exp_be);
      check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wd);
      check($sformatf("v%0d_busy", i), busy, 1);
      mem_ack = 1'b1; mem_rdata = vecs[i].rdata;
      tick();
      mem_ack = 1'b0;
      check($sformatf("v%0d_valid", i), resp_valid, 1);
      check($sformatf("v%0d_err", i), resp_err, 0);
      check($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rd);
      check($sformatf("v%0d_req_off", i), mem_req, 0);
      tick();
      check($sformatf("v%0d_pulse", i), resp_valid, 0);
      check($sformatf("v%0d_ready", i), req_ready, 1);
    end

    // Illegal or misaligned: error pulse at N+1, bus untouched.
    foreach (bads[i]) begin
      issue(bads[i].rd, bads[i].wr, bads[i].a, 64'h0);
      check($sformatf("bad%0d_valid", i), resp_valid, 1);
      check($sformatf("bad%0d_err", i), resp_err, 1);
      check($sformatf("bad%0d_req", i), mem_req, 0);
      check($sformatf("bad%0d_rdata", i), resp_rdata, 0);
      tick();
      check($sformatf("bad%0d_pulse", i), resp_valid, 0);
      check($sformatf("bad%0d_ready", i), req_ready, 1);
    end

    // sd with each beat acked two cycles late.
    issue(3'd0, 3'd4, 64'h3000, 64'h1122_3344_5566_7788);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("sd_b0_req%0d", c), mem_req, 1);
      check($sformatf("sd_b0_addr%0d", c), mem_addr, 32'h3000);
      check($sformatf("sd_b0_wd%0d", c), mem_wdata, 32'h5566_7788);
      check($sformatf("sd_b0_be%0d", c), mem_be, 4'b1111);
      mem_ack = (c == 2);
      tick();
    end
    mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("sd_b1_req%0d", c), mem_req, 1);
      check($sformatf("sd_b1_addr%0d", c), mem_addr, 32'h3004);
      check($sformatf("sd_b1_wd%0d", c), mem_wdata, 32'h1122_3344);
      check($sformatf("sd_b1_be%0d", c), mem_be, 4'b1111);
      check($sformatf("sd_b1_valid%0d", c), resp_valid, 0);
      mem_ack = (c == 2);
      tick();
    end
    mem_ack = 1'b0;
    check("sd_valid", resp_valid, 1);
    check("sd_err", resp_err, 0);
    check("sd_rdata", resp_rdata, 0);
    tick();

    // ld with immediate acks: resp_valid at N+3.
    issue(3'd6, 3'd0, 64'h6000, 64'h0);
    check("ld_b0_addr", mem_addr, 32'h6000);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("ld_b1_addr", mem_addr, 32'h6004);
    check("ld_b1_valid", resp_valid, 0);
    mem_rdata = 32'h0123_4567;
    tick();
    mem_ack = 1'b0;
    check("ld_valid", resp_valid, 1);
    check("ld_rdata", resp_rdata, 64'h0123_4567_DEAD_BEEF);
    tick();

    // ld with no ack: four request cycles, then timeout error.
    issue(3'd6, 3'd0, 64'h5000, 64'h0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("tmo_req%0d", c), mem_req, 1);
      check($sformatf("tmo_valid%0d", c), resp_valid, 0);
      tick();
    end
    check("tmo_req_drop", mem_req, 0);
    check("tmo_valid", resp_valid, 1);
    check("tmo_err", resp_err, 1);
    check("tmo_rdata", resp_rdata, 0);
    tick();
    check("tmo_ready", req_ready, 1);

    // Reset while waiting in B1.
    issue(3'd6, 3'd0, 64'h7000, 64'h0);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    check("mrst_in_b1", mem_addr, 32'h7004);
    rst_n = 1'b0;
    tick();
    check("mrst_req", mem_req, 0);
    check("mrst_ready", req_ready, 1);
    check("mrst_busy", busy, 0);
    check("mrst_valid", resp_valid, 0);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    tick();
    check("mrst_valid2", resp_valid, 0);
    check("mrst_req2", mem_req, 0);
    mem_ack = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
